// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared motion-estimation constants and loader state type
package me_pkg;
    localparam int DATA_W        = 64;
    localparam int DEPTH         = 288;
    localparam int WORDS_PER_ROW = 6;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        FULL = 1'b1
    } ld_state_t;
endpackage

// File: rtl/ref_bank.sv
// rtl/ref_bank.sv - single search-window bank, synchronous write, asynchronous read
module ref_bank #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 288,
    parameter int PTR_W  = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; a window is only trusted once fully loaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ref_mem_pingpong.sv
// rtl/ref_mem_pingpong.sv - double-buffered reference window memory for ME reads
module ref_mem_pingpong #(
    parameter int DATA_W = me_pkg::DATA_W,
    parameter int DEPTH  = me_pkg::DEPTH,
    parameter int ADDR_W = 32,
    parameter int PTR_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    input  logic              swap_i,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] ref_data,
    output logic              bank_full_o,
    output logic              rd_bank_o,
    output logic              ld_err_o
);
    import me_pkg::*;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    ld_state_t         state;
    logic              rd_bank;
    logic [PTR_W-1:0]  wr_ptr;
    logic              ld_err;
    logic              accept;
    logic              in_range;
    logic [PTR_W-1:0]  raddr;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    assign ld_ready_o  = (state == LOAD);
    assign bank_full_o = (state == FULL);
    assign rd_bank_o   = rd_bank;
    assign ld_err_o    = ld_err;
    assign accept      = ld_valid_i && ld_ready_o;

    // Full-width compare so huge addresses never alias into the bank.
    assign in_range = (addr < ADDR_W'(DEPTH));
    assign raddr    = addr[PTR_W-1:0];

    ref_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_bank0 (
        .clk   (clk),
        .we    (accept && rd_bank),
        .waddr (wr_ptr),
        .wdata (ld_data_i),
        .raddr (raddr),
        .rdata (rdata0)
    );

    ref_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_bank1 (
        .clk   (clk),
        .we    (accept && !rd_bank),
        .waddr (wr_ptr),
        .wdata (ld_data_i),
        .raddr (raddr),
        .rdata (rdata1)
    );

    always_comb begin
        ref_data = '0;
        if (en && in_range) begin
            ref_data = rd_bank ? rdata1 : rdata0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            rd_bank <= 1'b0;
            wr_ptr  <= '0;
            ld_err  <= 1'b0;
        end else begin
            ld_err <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (wr_ptr == LAST_PTR) begin
                            // Window length wins over a missing last marker.
                            wr_ptr <= '0;
                            state  <= FULL;
                            ld_err <= !ld_last_i;
                        end else if (ld_last_i) begin
                            wr_ptr <= '0;
                            ld_err <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (swap_i) begin
                        rd_bank <= !rd_bank;
                        wr_ptr  <= '0;
                        state   <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_ref_mem_pingpong.sv
// tb/tb_ref_mem_pingpong.sv - directed self-checking bench for ref_mem_pingpong
module tb_ref_mem_pingpong;
    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [63:0] ld_data_i;
    logic        ld_last_i;
    logic        swap_i;
    logic        en;
    logic [31:0] addr;
    logic [63:0] ref_data;
    logic        bank_full_o;
    logic        rd_bank_o;
    logic        ld_err_o;

    int checks = 0;
    int errors = 0;

    ref_mem_pingpong dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_data_i   (ld_data_i),
        .ld_last_i   (ld_last_i),
        .swap_i      (swap_i),
        .en          (en),
        .addr        (addr),
        .ref_data    (ref_data),
        .bank_full_o (bank_full_o),
        .rd_bank_o   (rd_bank_o),
        .ld_err_o    (ld_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [63:0] exp, input string tag);
        en   = 1'b1;
        addr = a;
        #1;
        check(tag, ref_data, exp);
    endtask

    task automatic fill(input logic [63:0] base, input int first, input int count, input int last_idx);
        for (int i = first; i < first + count; i++) begin
            ld_valid_i = 1'b1;
            ld_data_i  = base + 64'(i);
            ld_last_i  = (i == last_idx);
            step();
        end
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    task automatic swap();
        swap_i = 1'b1;
        step();
        swap_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ld_valid_i = 1'b0; ld_data_i = '0; ld_last_i = 1'b0;
        swap_i = 1'b0; en = 1'b0; addr = '0;
        #12;
        check("rst_ready", 64'(ld_ready_o), 64'd1);
        check("rst_full", 64'(bank_full_o), 64'd0);
        check("rst_rdbank", 64'(rd_bank_o), 64'd0);
        check("rst_err", 64'(ld_err_o), 64'd0);
        check("rst_refdata_en0", ref_data, 64'd0);
        step();
        rst = 1'b1;
        step();

        // Window A into bank 1: data = index
        fill(64'h0, 0, 287, 287);
        check("a_not_full_287", 64'(bank_full_o), 64'd0);
        fill(64'h0, 287, 1, 287);
        check("a_full", 64'(bank_full_o), 64'd1);
        check("a_ready_low", 64'(ld_ready_o), 64'd0);
        check("a_err", 64'(ld_err_o), 64'd0);
        swap();
        check("a_rdbank", 64'(rd_bank_o), 64'd1);
        check("a_full_fall", 64'(bank_full_o), 64'd0);
        check("a_ready_rise", 64'(ld_ready_o), 64'd1);
        rd(32'd0, 64'h0, "a_rd0");
        rd(32'd100, 64'h64, "a_rd100");
        rd(32'd287, 64'h11F, "a_rd287");

        // Window B into bank 0 while ME reads bank 1
        addr = 32'd100;
        fill(64'h1000, 0, 50, 287);
        rd(32'd100, 64'h64, "b_rd_mid");
        fill(64'h1000, 50, 238, 287);
        rd(32'd100, 64'h64, "b_rd_end");
        check("b_full", 64'(bank_full_o), 64'd1);
        swap_i = 1'b1;
        rd(32'd100, 64'h64, "b_rd_swapcycle");
        step();
        swap_i = 1'b0;
        check("b_rdbank", 64'(rd_bank_o), 64'd0);
        rd(32'd100, 64'h1064, "b_rd100");
        rd(32'd287, 64'h111F, "b_rd287");

        // Early last on beat 10
        fill(64'hAAAA, 0, 11, 10);
        check("e_err_pulse", 64'(ld_err_o), 64'd1);
        check("e_full", 64'(bank_full_o), 64'd0);
        step();
        check("e_err_clear", 64'(ld_err_o), 64'd0);
        fill(64'h2000, 0, 288, 287);
        check("e_full_after", 64'(bank_full_o), 64'd1);
        check("e_err_after", 64'(ld_err_o), 64'd0);
        swap();
        check("e_rdbank", 64'(rd_bank_o), 64'd1);
        rd(32'd0, 64'h2000, "e_rd0");
        rd(32'd10, 64'h200A, "e_rd10");

        // Missing last on beat 287
        fill(64'h3000, 0, 288, -1);
        check("m_err", 64'(ld_err_o), 64'd1);
        check("m_full", 64'(bank_full_o), 64'd1);
        step();
        check("m_err_clear", 64'(ld_err_o), 64'd0);
        swap();
        check("m_rdbank", 64'(rd_bank_o), 64'd0);
        rd(32'd5, 64'h3005, "m_rd5");

        // Swap while loading is ignored and keeps wr_ptr
        fill(64'h4000, 0, 20, 287);
        swap();
        check("s_rdbank", 64'(rd_bank_o), 64'd0);
        check("s_ready", 64'(ld_ready_o), 64'd1);
        check("s_err", 64'(ld_err_o), 64'd0);

        // Out-of-range and disabled reads
        rd(32'd288, 64'h0, "r_addr288");
        rd(32'hFFFF_FFFF, 64'h0, "r_addr_max");
        en = 1'b0; addr = 32'd5; #1;
        check("r_en0", ref_data, 64'h0);
        rd(32'd5, 64'h3005, "r_en1");

        fill(64'h4000, 20, 268, 287);
        check("s_full", 64'(bank_full_o), 64'd1);
        check("s_err_end", 64'(ld_err_o), 64'd0);
        swap();
        check("s_rdbank_after", 64'(rd_bank_o), 64'd1);
        rd(32'd20, 64'h4014, "s_rd20");

        // Reset mid-load
        fill(64'h5000, 0, 150, 287);
        rst = 1'b0;
        #1;
        check("x_ready", 64'(ld_ready_o), 64'd1);
        check("x_full", 64'(bank_full_o), 64'd0);
        check("x_rdbank", 64'(rd_bank_o), 64'd0);
        check("x_err", 64'(ld_err_o), 64'd0);
        step();
        rst = 1'b1;
        step();
        fill(64'h6000, 0, 287, 287);
        check("x_not_full_287", 64'(bank_full_o), 64'd0);
        check("x_no_err", 64'(ld_err_o), 64'd0);
        fill(64'h6000, 287, 1, 287);
        check("x_full_288", 64'(bank_full_o), 64'd1);
        swap();
        check("x_rdbank_swap", 64'(rd_bank_o), 64'd1);
        rd(32'd150, 64'h6096, "x_rd150");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ref_mem_pingpong.md
# ref_mem_pingpong

Double-buffered reference search-window memory that answers `ME_highBW`'s reference read port (`ref_mem_en`/`ref_mem_addr` -> `ref_in`). It also accepts the next search window from an upstream streaming loader. One bank serves motion-estimation reads combinationally while the other bank fills. An explicit swap exchanges the banks, so window loading overlaps the ME search. It is a drop-in replacement for the combinational `ref_mem` model at the ME boundary.

## Interface
- `DATA_W`, 64, word width; 8 pixels of 8 bits.
- `DEPTH`, 288, words per bank; 48 rows x 6 words.
- `ADDR_W`, 32, width of the ME read address.
- `PTR_W`, 9, load pointer width; must satisfy 2^PTR_W >= DEPTH.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ld_valid_i`  in  1  load beat valid.
- `ld_ready_o`  out  1  loader can accept a beat.
- `ld_data_i`  in  DATA_W  load beat payload.
- `ld_last_i`  in  1  marks the final beat of a window.
- `swap_i`  in  1  ME has finished with the current window; request a bank exchange.
- `en`  in  1  ME read enable.
- `addr`  in  ADDR_W  ME read word address.
- `ref_data`  out  DATA_W  read data, combinational.
- `bank_full_o`  out  1  shadow bank holds a complete window.
- `rd_bank_o`  out  1  index of the bank currently serving reads.
- `ld_err_o`  out  1  one-cycle pulse on a framing error.

## Operation
- Storage is two banks of DEPTH x DATA_W. The read bank is `rd_bank`; the load bank is `~rd_bank`. Memory contents are not reset.
- Read path: `ref_data = (en && addr < DEPTH) ? bank[rd_bank][addr] : 0`. The comparison against DEPTH uses the full ADDR_W-bit address. The ME samples `ref_data` in the same cycle it drives the address.
- Loader FSM has two states, LOAD and FULL.
  - LOAD: `ld_ready_o = 1`. A beat is accepted when `ld_valid_i & ld_ready_o`. An accepted beat writes `ld_data_i` to `bank[~rd_bank][wr_ptr]`.
  - If the accepted beat has `wr_ptr == DEPTH-1`, `wr_ptr` goes to 0 and the state goes to FULL. If `ld_last_i` is 0 on that beat, pulse `ld_err_o`; the window is still treated as complete.
  - If the accepted beat has `ld_last_i == 1` and `wr_ptr != DEPTH-1`, pulse `ld_err_o`, set `wr_ptr` to 0, and stay in LOAD. The partial window is discarded.
  - Otherwise `wr_ptr` increments.
  - FULL: `ld_ready_o = 0` and `bank_full_o = 1`. On `swap_i`, toggle `rd_bank`, set `wr_ptr` to 0, and go to LOAD.
- `swap_i` in LOAD is ignored: no toggle, no error, and no effect on `wr_ptr`.
- `ld_ready_o` and `swap_i` acting can never coincide, so there is no same-cycle load/swap conflict.
- Reset values:
  - FSM in LOAD; `rd_bank = 0`; `wr_ptr = 0`.
  - Outputs: `ld_ready_o = 1`, `bank_full_o = 0`, `rd_bank_o = 0`, `ld_err_o = 0`.
  - `ref_data` reflects the uninitialised bank 0 (0 when `en = 0`).
- Reset asserted mid-load abandons the partial window. No partial data is ever promoted to the read bank.

## Timing
- Read latency is 0 cycles (combinational from `en`/`addr`/`rd_bank`).
- Write latency is 1 cycle. A word written at edge N is visible in the load bank after edge N, but it is not readable by the ME until a swap.
- A swap sampled at edge N changes `rd_bank_o` after edge N. Reads in the swap cycle itself return the old bank.
- `ld_ready_o` rises in the cycle after the swap edge.
- Fill throughput is one beat per cycle with back-to-back valid. A full window fills in DEPTH cycles, 288 at the defaults.
- `ld_err_o` is registered. It is high for exactly the one cycle after the offending beat's edge.
- `bank_full_o` rises in the cycle after the final beat's edge. It falls in the cycle after the swap edge.

## Structure
- A shared package `me_pkg` holds `DATA_W`, `DEPTH` and the words-per-row constant (6), shared with `ME_highBW` and `cur_mem_highBW`. It also holds the `ld_state_t` enum {LOAD, FULL}.
- One sub-module is natural: `ref_bank`, a single-bank RAM with a synchronous write port and an asynchronous read port, instantiated twice. Write enable is steered by `~rd_bank`; the read mux is selected by `rd_bank`.
- The top level contains the FSM, `wr_ptr`, the bank select, the address range check and the output mux.

## Test plan
- Reset, then stream 288 beats with data = index and `ld_last` on beat 287, then pulse swap.
  - `bank_full_o` is 1 after beat 287; `rd_bank_o` is 1 after the swap.
  - Reads at `addr` 0, 100 and 287 return 0x0, 0x64 and 0x11F.
- Stream a window into bank 0 while ME reads bank 1.
  - Read data is unchanged during the fill.
  - After a second swap, `rd_bank_o` = 0 and the new data is read back.
- Send `ld_last` on beat 10 of a fill.
  - `ld_err_o` pulses for one cycle and `bank_full_o` stays 0.
  - A following correct 288-beat stream completes normally.
- Omit `ld_last` on beat 287.
  - `ld_err_o` pulses and `bank_full_o` = 1.
  - `swap_i` in LOAD mid-fill leaves `rd_bank_o` unchanged.
- Read with `addr` = 288, `addr` = 0xFFFF_FFFF, and `en` = 0 at `addr` 5 -> `ref_data` = 0 in all three cases.
- Assert `rst` low after 150 beats.
  - Outputs return to their reset values immediately (asynchronously).
  - A subsequent full fill of 288 beats is required before `bank_full_o` = 1.
